// File: rtl/fm_nco_modulator.sv
// FM modulator: sample FIFO, fixed-cadence consumer and phase-accumulator NCO.
// rf is the accumulator MSB; the increment is carrier plus the scaled sample.
module fm_nco_modulator #(
  parameter int clockRate        = 307_200_000,
  parameter int carrierFrequency = 106_500_000,
  parameter int phaseBits        = 32,
  parameter int sampleBits       = 24,
  parameter int deviationShift   = 7,
  parameter int sampleInterval   = 6400,
  parameter int fifoDepth        = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                carrierOnly,
  input  logic                                sampleValid,
  input  logic signed [sampleBits-1:0]        sampleData,
  output logic                                sampleReady,
  input  logic                                clearUnderrun,
  output logic                                underrun,
  output logic [$clog2(fifoDepth+1)-1:0]      fifoLevel,
  output logic                                rf
);

  localparam int PB = phaseBits;
  localparam int SB = sampleBits;
  localparam int AW = $clog2(fifoDepth);
  localparam int LW = $clog2(fifoDepth + 1);
  localparam int CW = $clog2(sampleInterval);

  localparam logic [127:0] NUM =
    (128'(1) << phaseBits) * 128'(carrierFrequency);
  localparam logic [127:0] CD_FULL =
    (NUM + 128'(clockRate / 2)) / 128'(clockRate);
  localparam logic [PB-1:0] CARRIER_DELTA = CD_FULL[PB-1:0];

  localparam logic [CW-1:0] CNT_LAST = CW'(sampleInterval - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(fifoDepth);

  logic [SB-1:0]        mem_q [fifoDepth];
  logic [AW-1:0]        wr_q, wr_d;
  logic [AW-1:0]        rd_q, rd_d;
  logic [LW-1:0]        level_q, level_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [SB-1:0] cur_sample_q, cur_sample_d;
  logic [PB-1:0]        phase_delta_q, phase_delta_d;
  logic [PB-1:0]        phase_q, phase_d;
  logic                 underrun_q, underrun_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          tick;
  logic [PB-1:0] ext;

  assign full        = (level_q == LVL_FULL);
  assign empty       = (level_q == '0);
  assign sampleReady = reset & ~full;
  assign push        = sampleValid & sampleReady;
  assign tick        = enable & (cnt_q == CNT_LAST);
  assign pop         = tick & ~empty;
  assign ext         = PB'(cur_sample_q);

  always_comb begin
    wr_d          = wr_q;
    rd_d          = rd_q;
    level_d       = level_q;
    cnt_d         = cnt_q;
    cur_sample_d  = cur_sample_q;
    underrun_d    = underrun_q;
    phase_delta_d = CARRIER_DELTA;
    phase_d       = '0;

    if (push) wr_d = wr_q + AW'(1);
    if (pop) begin
      rd_d         = rd_q + AW'(1);
      cur_sample_d = mem_q[rd_q];
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (enable) cnt_d = tick ? '0 : cnt_q + CW'(1);

    // An empty-FIFO tick outranks a same-cycle clear.
    if (tick && empty)      underrun_d = 1'b1;
    else if (clearUnderrun) underrun_d = 1'b0;

    if (!carrierOnly)
      phase_delta_d = CARRIER_DELTA + (ext << deviationShift);

    if (enable) phase_d = phase_q + phase_delta_q;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= sampleData;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q          <= '0;
      rd_q          <= '0;
      level_q       <= '0;
      cnt_q         <= '0;
      cur_sample_q  <= '0;
      phase_delta_q <= '0;
      phase_q       <= '0;
      underrun_q    <= 1'b0;
    end else begin
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      level_q       <= level_d;
      cnt_q         <= cnt_d;
      cur_sample_q  <= cur_sample_d;
      phase_delta_q <= phase_delta_d;
      phase_q       <= phase_d;
      underrun_q    <= underrun_d;
    end
  end

  assign underrun  = underrun_q;
  assign fifoLevel = level_q;
  assign rf        = phase_q[PB-1];

endmodule

// File: tb/tb_fm_nco_modulator.sv
// Directed bench for fm_nco_modulator with small parameters
// (carrier increment 64 in an 8-bit accumulator).
module tb_fm_nco_modulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       carrierOnly;
  logic       sampleValid;
  logic [3:0] sampleData;
  logic       sampleReady;
  logic       clearUnderrun;
  logic       underrun;
  logic [2:0] fifoLevel;
  logic       rf;

  int n_cmp = 0;
  int n_err = 0;

  fm_nco_modulator #(
    .clockRate(1000),
    .carrierFrequency(250),
    .phaseBits(8),
    .sampleBits(4),
    .deviationShift(2),
    .sampleInterval(4),
    .fifoDepth(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .carrierOnly(carrierOnly),
    .sampleValid(sampleValid),
    .sampleData(sampleData),
    .sampleReady(sampleReady),
    .clearUnderrun(clearUnderrun),
    .underrun(underrun),
    .fifoLevel(fifoLevel),
    .rf(rf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    enable        = 1'b0;
    carrierOnly   = 1'b0;
    sampleValid   = 1'b0;
    sampleData    = '0;
    clearUnderrun = 1'b0;
    step();
    reset = 1'b1;
  endtask

  task automatic push(input logic [3:0] d);
    sampleValid = 1'b1;
    sampleData  = d;
    step();
    sampleValid = 1'b0;
  endtask

  logic [3:0] rf_pat;

  initial begin
    rf_pat = 4'b1100;

    // 1: reset state, then carrier only from an empty FIFO
    do_reset();
    reset = 1'b0;
    step();
    check("rst_level", 32'(fifoLevel), 0);
    check("rst_ready", 32'(sampleReady), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_rf", 32'(rf), 0);
    check("rst_delta", 32'(dut.phase_delta_q), 0);
    check("rst_phase", 32'(dut.phase_q), 0);
    reset  = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) check("t1_delta", 32'(dut.phase_delta_q), 64);
      check("t1_rf", 32'(rf), 32'(rf_pat[i % 4]));
      check("t1_underrun", 32'(underrun), (i >= 3) ? 1 : 0);
    end

    // 2: +1, -8, +7 modulate the increment
    do_reset();
    push(4'd1);
    push(4'h8);
    push(4'd7);
    check("t2_level", 32'(fifoLevel), 3);
    enable = 1'b1;
    repeat (4) step();
    check("t2_level_pop", 32'(fifoLevel), 2);
    step();
    check("t2_delta_p1", 32'(dut.phase_delta_q), 68);
    repeat (3) step();
    check("t2_phase_wrap", 32'(dut.phase_q), 12);
    step();
    check("t2_delta_m8", 32'(dut.phase_delta_q), 32);
    repeat (4) step();
    check("t2_delta_p7", 32'(dut.phase_delta_q), 92);
    step();
    check("t2_phase", 32'(dut.phase_q), 44);

    // 3: fill while disabled, then drain
    do_reset();
    push(4'd1);
    push(4'd2);
    push(4'd3);
    push(4'd4);
    check("t3_full_level", 32'(fifoLevel), 4);
    check("t3_full_ready", 32'(sampleReady), 0);
    push(4'd5);
    check("t3_ignored", 32'(fifoLevel), 4);
    enable = 1'b1;
    repeat (3) step();
    check("t3_pre_level", 32'(fifoLevel), 4);
    check("t3_pre_ready", 32'(sampleReady), 0);
    step();
    check("t3_pop1_level", 32'(fifoLevel), 3);
    check("t3_pop1_ready", 32'(sampleReady), 1);
    repeat (4) step();
    check("t3_pop2_level", 32'(fifoLevel), 2);
    repeat (4) step();
    check("t3_pop3_level", 32'(fifoLevel), 1);
    repeat (4) step();
    check("t3_pop4_level", 32'(fifoLevel), 0);
    check("t3_underrun", 32'(underrun), 0);
    step();
    check("t3_delta", 32'(dut.phase_delta_q), 80);

    // 4: carrier-only still consumes samples
    do_reset();
    push(4'h8);
    push(4'h8);
    carrierOnly = 1'b1;
    enable      = 1'b1;
    repeat (4) step();
    check("t4_level1", 32'(fifoLevel), 1);
    step();
    check("t4_delta1", 32'(dut.phase_delta_q), 64);
    repeat (3) step();
    check("t4_level0", 32'(fifoLevel), 0);
    step();
    check("t4_delta2", 32'(dut.phase_delta_q), 64);

    // 5: underrun versus clear
    carrierOnly = 1'b0;
    step();
    check("t5_delta", 32'(dut.phase_delta_q), 32);
    check("t5_no_ur", 32'(underrun), 0);
    repeat (2) step();
    check("t5_ur", 32'(underrun), 1);
    repeat (3) step();
    clearUnderrun = 1'b1;
    step();
    check("t5_clr_tick", 32'(underrun), 1);
    step();
    clearUnderrun = 1'b0;
    check("t5_clr", 32'(underrun), 0);
    check("t5_hold", 32'(dut.phase_delta_q), 32);

    // 6: reset mid-operation
    do_reset();
    enable = 1'b1;
    repeat (4) step();
    check("t6_ur", 32'(underrun), 1);
    push(4'd1);
    push(4'd2);
    push(4'd3);
    check("t6_level", 32'(fifoLevel), 3);
    check("t6_phase", 32'(dut.phase_q), 128);
    reset = 1'b0;
    step();
    check("t6_ready", 32'(sampleReady), 0);
    reset = 1'b1;
    check("t6_r_level", 32'(fifoLevel), 0);
    check("t6_r_phase", 32'(dut.phase_q), 0);
    check("t6_r_rf", 32'(rf), 0);
    check("t6_r_ur", 32'(underrun), 0);
    check("t6_r_delta", 32'(dut.phase_delta_q), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
